puf_response_reader: RTL and testbench

- Controller that drives the PUF core's challenge side and reads its responses back.
- Sweeps all 2^ADDR_W challenge addresses and re-evaluates the PUF NUM_READS times per address.
- Majority-votes each response bit and flags unstable bits.
- Streams one voted record per address over a valid/ready interface to downstream logic (enrollment store / output mux in the top-level wrapper).

---
 rtl/puf_response_reader.sv | 148 ++++++++++++++
 tb/tb_puf_response_reader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_reader.sv
// Sweeps every PUF challenge address, re-evaluates the PUF several times per
// address, majority-votes each response bit and streams one record per address.
module puf_response_reader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int NUM_READS = 5,
    parameter int SETTLE    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              puf_start,
    output logic [ADDR_W-1:0] puf_addr,
    input  logic [DATA_W-1:0] puf_resp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_unstable,
    output logic [7:0]        unstable_total,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(NUM_READS + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int PW = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESTART = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_SAMPLE  = 3'd3;
    localparam logic [2:0] S_VOTE    = 3'd4;
    localparam logic [2:0] S_PRESENT = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
    localparam logic [CW-1:0]     READS_LAST  = CW'(NUM_READS - 1);
    localparam logic [CW-1:0]     READS_ALL   = CW'(NUM_READS);
    localparam logic [CW-1:0]     READS_HALF  = CW'(NUM_READS / 2);
    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);

    logic [2:0]                 state;
    logic [DATA_W-1:0][CW-1:0]  cnt;
    logic [CW-1:0]              read_cnt;
    logic [SW-1:0]              settle_cnt;
    logic [DATA_W-1:0]          vote_data;
    logic [DATA_W-1:0]          vote_unst;
    logic [PW-1:0]              unst_pop;
    logic [8:0]                 total_sum;

    // Valid/ready: a record transfers on any rising edge where out_valid and
    // out_ready are both high; the record is held unchanged until then.
    always_comb begin
        vote_data = '0;
        vote_unst = '0;
        unst_pop  = '0;
        for (int i = 0; i < DATA_W; i++) begin
            vote_data[i] = (cnt[i] > READS_HALF);
            vote_unst[i] = (cnt[i] != '0) && (cnt[i] != READS_ALL);
            unst_pop     = unst_pop + PW'(vote_unst[i]);
        end
        total_sum = {1'b0, unstable_total} + 9'(unst_pop);
    end

    assign puf_start = (state == S_SETTLE) || (state == S_SAMPLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            read_cnt       <= '0;
            settle_cnt     <= '0;
            puf_addr       <= '0;
            out_valid      <= 1'b0;
            out_addr       <= '0;
            out_data       <= '0;
            out_unstable   <= '0;
            unstable_total <= '0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            // Abort wins over everything except an idle start request.
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state          <= S_RESTART;
                            puf_addr       <= '0;
                            unstable_total <= '0;
                            cnt            <= '0;
                            read_cnt       <= '0;
                        end
                    end
                    S_RESTART: begin
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state <= S_SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            cnt[i] <= cnt[i] + CW'(puf_resp[i]);
                        end
                        read_cnt <= read_cnt + 1'b1;
                        state    <= (read_cnt == READS_LAST) ? S_VOTE : S_RESTART;
                    end
                    S_VOTE: begin
                        out_data       <= vote_data;
                        out_unstable   <= vote_unst;
                        out_addr       <= puf_addr;
                        unstable_total <= total_sum[8] ? 8'hFF : total_sum[7:0];
                        out_valid      <= 1'b1;
                        state          <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (puf_addr == LAST_ADDR) begin
                                done  <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                puf_addr <= puf_addr + 1'b1;
                                cnt      <= '0;
                                read_cnt <= '0;
                                state    <= S_RESTART;
                            end
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_response_reader.sv
// Directed bench for puf_response_reader: a PUF model drives responses, a
// scoreboard queue holds expected records and a monitor pops on each handshake.
module tb_puf_response_reader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int RW     = ADDR_W + 2 * DATA_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              puf_start;
    logic [ADDR_W-1:0] puf_addr;
    logic [DATA_W-1:0] puf_resp;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_unstable;
    logic [7:0]        unstable_total;
    logic              busy;
    logic              done;

    int checks;
    int errors;
    int done_cnt;
    logic flip_mode;
    logic [RW-1:0] exp_q[$];

    puf_response_reader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .puf_start      (puf_start),
        .puf_addr       (puf_addr),
        .puf_resp       (puf_resp),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .out_unstable   (out_unstable),
        .unstable_total (unstable_total),
        .busy           (busy),
        .done           (done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PUF model: read number = count of puf_start rising edges at this address
    int          rd;
    logic        ps_prev;
    logic [ADDR_W-1:0] last_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd        <= 0;
            ps_prev   <= 1'b0;
            last_addr <= '0;
        end else begin
            ps_prev   <= puf_start;
            last_addr <= puf_addr;
            if (puf_addr != last_addr) rd <= 0;
            else if (puf_start && !ps_prev) rd <= rd + 1;
        end
    end

    always_comb begin
        puf_resp = {puf_addr, puf_addr};
        if (flip_mode && puf_addr == 4'd3) begin
            puf_resp = 8'hA5;
            if (rd == 2 || rd == 4) puf_resp = 8'hA4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", {12'd0, out_addr, out_data, out_unstable}, 32'hFFFFFFFF);
            end else begin
                check("record", {12'd0, out_addr, out_data, out_unstable}, {12'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic push_sweep(input int last, input logic flip);
        for (int a = 0; a <= last; a++) begin
            if (flip && a == 3) exp_q.push_back({4'd3, 8'hA5, 8'h01});
            else exp_q.push_back({4'(a), 8'(a * 17), 8'h00});
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        check({name, "_idle_timeout"}, 32'(n < 3000), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        check({name, "_valid_timeout"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        int first_valid;
        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        flip_mode = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;

        // reset values
        #2;
        check("reset_outputs", {puf_start, out_valid, busy, done, 4'd0, unstable_total},
              32'd0);
        check("reset_data", {4'd0, puf_addr, out_addr, out_data, out_unstable}, 32'd0);
        do_reset();

        // stable sweep, with puf_start pattern and first-valid latency
        push_sweep(15, 1'b0);
        pulse_start();
        first_valid = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            // RESTART low, then SETTLE (4) and SAMPLE (1) high, per read; VOTE low
            if (c <= 31) check("puf_start_pattern", 32'(puf_start),
                               32'((c <= 30) && ((c - 1) % 6 != 0)));
            if (out_valid && first_valid == 0) first_valid = c;
            @(posedge clk);
            #1;
        end
        check("first_valid_cycle", 32'(first_valid), 32'd32);
        wait_idle("sweep1");
        check("sweep1_done", 32'(done_cnt), 32'd1);
        check("sweep1_total", 32'(unstable_total), 32'd0);
        check("sweep1_busy", 32'(busy), 32'd0);
        check("sweep1_queue", 32'(exp_q.size()), 32'd0);

        // one unstable bit at address 3
        flip_mode = 1'b1;
        done_cnt  = 0;
        push_sweep(15, 1'b1);
        pulse_start();
        wait_idle("sweep2");
        check("sweep2_done", 32'(done_cnt), 32'd1);
        check("sweep2_total", 32'(unstable_total), 32'd1);
        check("sweep2_queue", 32'(exp_q.size()), 32'd0);
        flip_mode = 1'b0;

        // backpressure on record 0
        done_cnt  = 0;
        out_ready = 1'b0;
        push_sweep(15, 1'b0);
        pulse_start();
        wait_valid("bp");
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold", {8'd0, 3'd0, out_valid, out_addr, out_data, puf_addr, puf_start, 3'd0},
                  {8'd0, 3'd0, 1'b1, 4'd0, 8'h00, 4'd0, 1'b0, 3'd0});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_addr_next", 32'(puf_addr), 32'd1);
        check("bp_valid_drop", 32'(out_valid), 32'd0);
        wait_idle("bp");
        check("bp_done", 32'(done_cnt), 32'd1);
        check("bp_queue", 32'(exp_q.size()), 32'd0);

        // abort during SETTLE of address 7
        done_cnt = 0;
        push_sweep(6, 1'b0);
        pulse_start();
        begin
            int n;
            n = 0;
            while (!(puf_addr == 4'd7 && puf_start) && n < 500) begin
                @(posedge clk);
                #1 n++;
            end
            check("abort_reach_addr7", 32'(n < 500), 32'd1);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_state", {busy, puf_start, out_valid, done}, 4'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        push_sweep(15, 1'b0);
        pulse_start();
        check("restart_addr0", {busy, 3'd0, puf_addr}, {1'b1, 3'd0, 4'd0});
        wait_idle("restart");
        check("restart_done", 32'(done_cnt), 32'd1);
        check("restart_queue", 32'(exp_q.size()), 32'd0);

        // start while busy, then reset during PRESENT
        out_ready = 1'b0;
        exp_q.push_back({4'd0, 8'h00, 8'h00});
        pulse_start();
        wait_valid("rst");
        pulse_start();
        check("busy_start_ignored", {out_valid, 3'd0, puf_addr, out_addr}, {1'b1, 3'd0, 4'd0, 4'd0});
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {puf_start, out_valid, busy, done, 4'd0, unstable_total}, 32'd0);
        check("async_reset_data", {4'd0, puf_addr, out_addr, out_data, out_unstable}, 32'd0);
        exp_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", {busy, out_valid}, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
